// File: rtl/xalu_nibble_seq.sv
// xalu_nibble_seq: builds a NIBBLES x 4-bit ALU from one combinational 4-bit
// slice. Wide operands are latched and fed to the slice one nibble per clock,
// with carry/shift chaining between nibbles. The wide result and the status
// flags are assembled from the slice's outputs.
//
// Handshake: a request is accepted on any clock edge where start=1 and
// ready=1. ready is high in IDLE and DONE. start is ignored while in RUN.
// done pulses for one cycle when result and flags are valid. They hold
// until the next accepted start clears them.
module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic                   com,
  input  logic                   ci,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   ready,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   co,
  output logic                   zero,
  output logic                   neg_zero,
  output logic                   equ,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_f,
  output logic                   alu_com,
  output logic                   alu_ci_right,
  output logic                   alu_ci_left,
  input  logic [3:0]             alu_d,
  input  logic                   alu_co_left,
  input  logic                   alu_co_right,
  output logic [1:0]             state_dbg
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [2:0]    OP_ADD   = 3'd0;
  localparam logic [2:0]    OP_SHR   = 3'd6;
  localparam logic [2:0]    OP_SHL   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [2:0]      op_q;
  logic            com_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            accept;
  logic            last_nib;
  logic            carry_nxt;
  logic            keeps_carry;
  logic [W-1:0]    res_nxt;

  assign accept    = start && ready;
  // SHR walks from the top nibble down; every other op walks upward.
  assign last_nib  = (op_q == OP_SHR) ? (idx_q == '0) : (idx_q == LAST_IDX);
  // SHR shifts toward the right edge, so its chain leaves on the right.
  assign carry_nxt = (op_q == OP_SHR) ? alu_co_right : alu_co_left;
  // Only arithmetic and shift ops report a carry. Logic ops chain one,
  // but it is discarded.
  assign keeps_carry = (op_q == OP_ADD) || (op_q == OP_SHR) || (op_q == OP_SHL);
  assign state_dbg = state_q;

  // The slice is driven straight from latched state. The index and carry
  // freeze on the last nibble, so these hold their values outside RUN.
  always_comb begin
    alu_a        = a_q[int'(idx_q)*4 +: 4];
    alu_b        = b_q[int'(idx_q)*4 +: 4];
    alu_f        = op_q;
    alu_com      = com_q;
    alu_ci_left  = (op_q == OP_SHR) ? carry_q : 1'b0;
    alu_ci_right = (op_q == OP_SHR) ? 1'b0 : carry_q;
  end

  // The result as it will stand after this edge. Flags are taken from it.
  always_comb begin
    res_nxt = result;
    res_nxt[int'(idx_q)*4 +: 4] = alu_d;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    ready   = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        ready = 1'b0;
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, nibble walk, result assembly and flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      com_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result   <= '0;
      co       <= 1'b0;
      zero     <= 1'b0;
      neg_zero <= 1'b0;
      equ      <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      op_q     <= op;
      com_q    <= com;
      carry_q  <= ci;
      idx_q    <= (op == OP_SHR) ? LAST_IDX : '0;
      result   <= '0;
      co       <= 1'b0;
      zero     <= 1'b0;
      neg_zero <= 1'b0;
      equ      <= 1'b0;
    end else if (state_q == RUN) begin
      result[int'(idx_q)*4 +: 4] <= alu_d;
      if (last_nib) begin
        co       <= keeps_carry ? carry_nxt : 1'b0;
        zero     <= (res_nxt == '0);
        neg_zero <= (res_nxt == '1);
        equ      <= (a_q == b_q);
      end else begin
        carry_q <= carry_nxt;
        if (op_q == OP_SHR) idx_q <= idx_q - 1'b1;
        else                idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule
